// File: rtl/silly_kernel_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | silly_kernel_core: single-cycle 8-bit core running a fixed ROM program    |
// | that doubles the switch value and shows it on two 7-segment digits.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module silly_kernel_core (
    input  logic       clk_i,
    input  logic       reset,
    input  logic [9:0] SW_i,
    output logic [6:0] HEX_1_o,
    output logic [6:0] HEX_2_o
);

    localparam logic [2:0] C_OP_LDI = 3'd0;
    localparam logic [2:0] C_OP_IN  = 3'd1;
    localparam logic [2:0] C_OP_ADD = 3'd2;
    localparam logic [2:0] C_OP_SUB = 3'd3;
    localparam logic [2:0] C_OP_AND = 3'd4;
    localparam logic [2:0] C_OP_BEQ = 3'd5;
    localparam logic [2:0] C_OP_OUT = 3'd6;
    localparam logic [2:0] C_OP_JMP = 3'd7;

    localparam logic [15:0] C_I_IN_R1  = 16'h2400; // IN  r1
    localparam logic [15:0] C_I_ADD    = 16'h4890; // ADD r2,r1,r1
    localparam logic [15:0] C_I_OUT_R2 = 16'hC100; // OUT r2
    localparam logic [15:0] C_I_JMP0   = 16'hE000; // JMP 0

    logic [4:0]  pc_q, pc_d;
    logic [7:0]  regs_q [8];
    logic [7:0]  regs_d [8];
    logic [7:0]  disp_q, disp_d;

    logic [15:0] instr;
    logic [2:0]  op, rd, rs1, rs2;
    logic [7:0]  imm8, rs1_val, rs2_val, wr_data;
    logic [4:0]  target;
    logic        wr_en;
    logic        unused_sw;

    assign unused_sw = ^SW_i[9:8];

    always_comb begin
        instr = C_I_JMP0;
        case (pc_q)
            5'd0:    instr = C_I_IN_R1;
            5'd1:    instr = C_I_ADD;
            5'd2:    instr = C_I_OUT_R2;
            default: instr = C_I_JMP0;
        endcase
    end

    assign op      = instr[15:13];
    assign rd      = instr[12:10];
    assign rs1     = instr[9:7];
    assign rs2     = instr[6:4];
    assign imm8    = instr[7:0];
    assign target  = instr[4:0];
    // r0 is held at zero by reset and never written, so it reads as zero.
    assign rs1_val = regs_q[rs1];
    assign rs2_val = regs_q[rs2];

    always_comb begin
        pc_d    = pc_q + 5'd1;
        regs_d  = regs_q;
        disp_d  = disp_q;
        wr_en   = 1'b0;
        wr_data = 8'd0;
        case (op)
            C_OP_LDI: begin wr_en = 1'b1; wr_data = imm8;              end
            C_OP_IN:  begin wr_en = 1'b1; wr_data = SW_i[7:0];         end
            C_OP_ADD: begin wr_en = 1'b1; wr_data = rs1_val + rs2_val; end
            C_OP_SUB: begin wr_en = 1'b1; wr_data = rs1_val - rs2_val; end
            C_OP_AND: begin wr_en = 1'b1; wr_data = rs1_val & rs2_val; end
            C_OP_BEQ: if (rs1_val == rs2_val) pc_d = target;
            C_OP_OUT: disp_d = rs1_val;
            C_OP_JMP: pc_d = target;
            default:  pc_d = pc_q + 5'd1;
        endcase
        if (wr_en && (rd != 3'd0)) begin
            regs_d[rd] = wr_data;
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            pc_q   <= 5'd0;
            regs_q <= '{default: 8'd0};
            disp_q <= 8'd0;
        end else begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
            disp_q <= disp_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        s = 7'b1000000;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    assign HEX_1_o = seg7(disp_q[3:0]);
    assign HEX_2_o = seg7(disp_q[7:4]);

endmodule
`default_nettype wire

// File: tb/tb_silly_kernel_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_silly_kernel_core: random switch stimulus against a reference model   |
// | of the doubling program, plus directed display cases.                    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_silly_kernel_core;

    logic       clk_i;
    logic       reset;
    logic [9:0] SW_i;
    logic [6:0] HEX_1_o;
    logic [6:0] HEX_2_o;

    int n_cmp;
    int n_err;

    // Reference model state: edges since reset release, latched switch, display.
    int         m_edges;
    logic [7:0] m_sampled;
    logic [7:0] m_disp;

    localparam logic [6:0] C_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [13:0] C_HEX_00 = {7'b1000000, 7'b1000000};

    silly_kernel_core u_dut (
        .clk_i   (clk_i),
        .reset   (reset),
        .SW_i    (SW_i),
        .HEX_1_o (HEX_1_o),
        .HEX_2_o (HEX_2_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got HEX2/HEX1=%b_%b expected %b_%b at %0t",
                     tag, obs[13:7], obs[6:0], exp[13:7], exp[6:0], $time);
        end
    endtask

    function automatic logic [13:0] hex_of(input logic [7:0] v);
        return {C_SEG[v / 16], C_SEG[v % 16]};
    endfunction

    // The program repeats IN / ADD / OUT / JMP; only IN and OUT are observable.
    task automatic model_edge();
        case (m_edges % 4)
            0: m_sampled = SW_i[7:0];
            2: m_disp = 8'((int'(m_sampled) * 2) % 256);
            default: ;
        endcase
        m_edges++;
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            model_edge();
            @(negedge clk_i);
            check_val(tag, {HEX_2_o, HEX_1_o}, hex_of(m_disp));
        end
    endtask

    // Asynchronous reset asserted between edges, held over two edges, released at negedge.
    task automatic do_reset(input string tag);
        @(negedge clk_i);
        #2;
        reset = 1'b1;
        #1;
        check_val(tag, {HEX_2_o, HEX_1_o}, C_HEX_00);
        m_edges   = 0;
        m_sampled = 8'd0;
        m_disp    = 8'd0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_val({tag, "_held"}, {HEX_2_o, HEX_1_o}, C_HEX_00);
        reset = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        m_edges   = 0;
        m_sampled = 8'd0;
        m_disp    = 8'd0;
        reset     = 1'b1;
        SW_i      = 10'd50;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_val("reset_hold", {HEX_2_o, HEX_1_o}, C_HEX_00);
        reset = 1'b0;

        run(2, "post_reset_e12");
        check_val("post_reset_still00", {HEX_2_o, HEX_1_o}, C_HEX_00);
        run(1, "edge3");
        check_val("sw50", {HEX_2_o, HEX_1_o}, {7'b0000010, 7'b0011001});
        run(22, "sw50_hold");
        check_val("sw50_steady", {HEX_2_o, HEX_1_o}, {7'b0000010, 7'b0011001});

        // Change mid-loop (just after an IN edge would be worst case).
        SW_i = 10'd5;
        run(7, "sw5_transition");
        check_val("sw5", {HEX_2_o, HEX_1_o}, {7'b1000000, 7'b0001000});

        SW_i = 10'd128;
        run(8, "sw128");
        check_val("sw128_wrap", {HEX_2_o, HEX_1_o}, C_HEX_00);

        SW_i = 10'b1111111111;
        run(8, "sw3ff");
        check_val("sw3ff_ignore_hi", {HEX_2_o, HEX_1_o}, {7'b0001110, 7'b0000110});

        SW_i = 10'd50;
        run(6, "pre_async");
        do_reset("async_reset");
        run(2, "restart_e12");
        check_val("restart_still00", {HEX_2_o, HEX_1_o}, C_HEX_00);
        run(1, "restart_e3");
        check_val("restart_sw50", {HEX_2_o, HEX_1_o}, {7'b0000010, 7'b0011001});

        for (int k = 0; k < 60; k++) begin
            SW_i = 10'($urandom);
            run(int'($urandom_range(1, 9)), "random");
            if ($urandom_range(0, 15) == 0) begin
                do_reset("random_reset");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/silly_kernel_core.md
# silly_kernel_core

Minimal single-cycle 8-bit programmable core with a fixed program in internal ROM. It reads the board slide switches, computes on them, and shows one 8-bit result register as two hexadecimal digits on active-low 7-segment displays. It is the top-level demo block of the processor project and has no bus or memory interfaces.

## Interface
- No parameters. Program ROM contents, register count and display encoding are fixed as specified below.
- One clock; reset is asynchronous and active-high.
- clk_i  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- SW_i  in  10  slide switches. Bits [7:0] are the IN operand; bits [9:8] are ignored.
- HEX_1_o  out  7  low nibble of the display register, 7-segment, active-low, bit order {g,f,e,d,c,b,a}.
- HEX_2_o  out  7  high nibble of the display register, same encoding.

## Operation
- State:
  - pc[4:0], indexing a 32-entry ROM of 16-bit instructions.
  - 8 registers r0..r7, each 8 bits. r0 always reads 0 and ignores writes.
  - disp[7:0], the display register.
- Instruction fields: op=[15:13], rd=[12:10], rs1=[9:7], rs2=[6:4], imm8=[7:0], target=[4:0].
- Opcodes:
  - 0 LDI: rd<=imm8.
  - 1 IN: rd<=SW_i[7:0], sampled at the executing edge.
  - 2 ADD: rd<=rs1+rs2, mod 256.
  - 3 SUB: rd<=rs1-rs2, mod 256, two's-complement wrap.
  - 4 AND: rd<=rs1&rs2.
  - 5 BEQ: if rs1==rs2 then pc<=target, else pc+1.
  - 6 OUT: disp<=rs1.
  - 7 JMP: pc<=target.
- PC rules: all non-branch instructions do pc<=pc+1, wrapping 31->0. Taken BEQ and JMP do not write a register.
- Fixed program:
  - 0: IN r1
  - 1: ADD r2,r1,r1
  - 2: OUT r2
  - 3: JMP 0
  - 4..31: JMP 0, as a trap to restart.
- Net effect: disp = (2*SW_i[7:0]) mod 256, refreshed every 4 cycles.
- Display decode, combinational from disp. HEX_1_o=seg(disp[3:0]), HEX_2_o=seg(disp[7:4]).
- seg codes, digit:{g..a}:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110

## Timing
- Reset, asserted asynchronously: pc=0, r1..r7=0, disp=0.
- Outputs during reset: HEX_1_o=HEX_2_o=1000000 (shows "00").
- Reset asserted mid-program: the current instruction is aborted and no partial writes occur.
- Single-cycle: one instruction retires per rising edge with reset low, and every register/disp write lands on that edge.
- After reset deassertion:
  - edge 1 executes ROM[0] (IN);
  - edge 2 executes ADD;
  - edge 3 executes OUT, so the outputs show the new value after edge 3;
  - edge 4 executes JMP.
- Loop period is 4 cycles. A switch change is reflected on HEX within at most 7 rising edges.
- SW_i is sampled only at IN edges. Changes at other edges have no effect until the next IN.
- HEX outputs change only after edges that write disp, or immediately on reset. There are no glitches from other instructions.

## Test plan
- Assert reset, then hold it 2 cycles -> HEX_1_o=HEX_2_o=1000000. Release reset -> still 1000000 after edges 1-2.
- SW_i=0000110010 (50) after reset -> after edge 3, disp=0x64: HEX_1_o=0011001 ("4"), HEX_2_o=0000010 ("6"). Value holds steady over 20+ cycles.
- SW_i=0010000000 (128) -> disp=0x00 (wrap): both outputs 1000000.
- SW_i=1111111111 -> bits [9:8] ignored, disp=0xFE: HEX_1_o=0000110 ("E"), HEX_2_o=0001110 ("F").
- Change SW_i from 50 to 5 mid-loop -> disp=0x0A within 7 edges (HEX_1_o=0001000, HEX_2_o=1000000), with no intermediate value.
- Assert reset asynchronously mid-loop, between edges -> outputs become 1000000 immediately without waiting for a clock edge. After release, the program restarts at pc 0.
